// File: rtl/adder_sum_pipe_pkg.sv
// Shared constants and types for the adder sum stage: datapath width,
// flag bit positions on the result bus and the OUT/SKID occupancy states.
package adder_sum_pipe_pkg;

  // Default datapath width; every module exposes it as an overridable parameter.
  localparam int LEN_DATA = 64;

  // Flag bit positions when the flags are packed onto the result bus.
  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  // Occupancy of the two storage entries: nothing, OUT only, OUT and SKID.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Packs the four flags into their bus positions.
  function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic c, input logic v,
                                                      input logic z, input logic n);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/adder_sum_pipe_if.sv
// Handshake bundle between the prefix tree (source), the sum stage and the
// ALU result bus (sink). The sum stage uses the slave view.
interface adder_sum_pipe_if #(
  parameter int LEN_DATA = adder_sum_pipe_pkg::LEN_DATA
);

  // Input channel from the last prefix stage.
  logic                in_valid;
  logic                in_ready;
  logic [LEN_DATA-1:0] g_grp;
  logic [LEN_DATA-1:0] p_grp;
  logic [LEN_DATA-1:0] p_bit;
  logic                cin;

  // Output channel towards the result bus.
  logic                out_valid;
  logic                out_ready;
  logic [LEN_DATA-1:0] sum;
  logic                cout;
  logic                ovf;
  logic                zero;
  logic                neg;

  modport master (
    output in_valid, g_grp, p_grp, p_bit, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, g_grp, p_grp, p_bit, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );

endinterface

// File: rtl/adder_sum_pipe_calc.sv
// Combinational sum and flag generation from the final prefix-stage
// group generate/propagate vectors and the carry-in.
module adder_sum_calc #(
  parameter int LEN_DATA = adder_sum_pipe_pkg::LEN_DATA
) (
  input  logic [LEN_DATA-1:0] g_grp,
  input  logic [LEN_DATA-1:0] p_grp,
  input  logic [LEN_DATA-1:0] p_bit,
  input  logic                cin,
  output logic [LEN_DATA-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                zero,
  output logic                neg
);

  // carry[i] is the carry into bit i; group terms exclude cin, so it is folded in here.
  logic [LEN_DATA:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < LEN_DATA; gi++) begin : g_bit
      assign carry[gi+1] = g_grp[gi] | (p_grp[gi] & cin);
      assign sum[gi]     = p_bit[gi] ^ carry[gi];
    end
  endgenerate

  assign cout = carry[LEN_DATA];
  assign ovf  = carry[LEN_DATA] ^ carry[LEN_DATA-1];
  assign zero = ~|sum;
  assign neg  = sum[LEN_DATA-1];

endmodule

// File: rtl/adder_sum_pipe.sv
// Final adder stage: computes sum and flags for each accepted bundle and
// registers them in an OUT entry backed by a one-deep SKID entry, so the
// upstream prefix tree sees a registered in_ready and is never stalled mid-path.
module adder_sum_pipe #(
  parameter int LEN_DATA = adder_sum_pipe_pkg::LEN_DATA
) (
  input  logic                clk,
  input  logic                rst_n,
  adder_sum_pipe_if.slave     bus
);

  import adder_sum_pipe_pkg::*;

  // Result and flags travel together through both storage entries.
  typedef struct packed {
    logic [LEN_DATA-1:0]  sum;
    logic [NUM_FLAGS-1:0] flags;
  } bundle_t;

  logic [LEN_DATA-1:0] calc_sum;
  logic                calc_cout;
  logic                calc_ovf;
  logic                calc_zero;
  logic                calc_neg;
  bundle_t             calc_bundle;

  state_t              state_reg;
  bundle_t             out_reg;
  bundle_t             skid_reg;
  logic                out_valid_reg;
  logic                in_ready_reg;

  logic                accept;
  logic                drain;

  adder_sum_calc #(
    .LEN_DATA (LEN_DATA)
  ) u_calc (
    .g_grp (bus.g_grp),
    .p_grp (bus.p_grp),
    .p_bit (bus.p_bit),
    .cin   (bus.cin),
    .sum   (calc_sum),
    .cout  (calc_cout),
    .ovf   (calc_ovf),
    .zero  (calc_zero),
    .neg   (calc_neg)
  );

  assign calc_bundle.sum   = calc_sum;
  assign calc_bundle.flags = pack_flags(calc_cout, calc_ovf, calc_zero, calc_neg);

  // in_ready is taken from its register, so out_ready never reaches it combinationally.
  assign accept = bus.in_valid & in_ready_reg;
  assign drain  = out_valid_reg & bus.out_ready;

  // OUT/SKID occupancy machine; out_valid and in_ready are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      out_reg       <= '0;
      skid_reg      <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            out_reg       <= calc_bundle;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            // OUT is replaced in the same cycle it leaves: full throughput.
            out_reg <= calc_bundle;
          end else if (accept) begin
            // OUT is stalled, park the new bundle and close the input.
            skid_reg     <= calc_bundle;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_TWO;
          end else if (drain) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            out_reg      <= skid_reg;
            in_ready_reg <= 1'b1;
            state_reg    <= ST_ONE;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = out_reg.sum;
  assign bus.cout      = out_reg.flags[FLAG_C];
  assign bus.ovf       = out_reg.flags[FLAG_V];
  assign bus.zero      = out_reg.flags[FLAG_Z];
  assign bus.neg       = out_reg.flags[FLAG_N];

endmodule

// File: doc/adder_sum_pipe.md
Name: adder_sum_pipe

Overview:
- Final stage of the parallel-prefix adder. Consumes the group generate/propagate vectors produced by the last prefix stage, plus the bitwise propagate and the carry-in.
- Produces the registered sum together with carry-out, signed-overflow, zero and negative flags.
- Sits between the prefix tree and the ALU result bus. Uses a valid/ready handshake with a 2-entry skid buffer so the combinational tree is never stalled mid-path.

Parameters:
- LEN_DATA, 64, datapath width in bits; taken from main.def.v and overridable.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input bundle valid
- in_ready  output  1  block can accept a bundle this cycle
- g_grp  input  LEN_DATA  group generate G[i:0] for each bit i, computed without carry-in
- p_grp  input  LEN_DATA  group propagate P[i:0] for each bit i
- p_bit  input  LEN_DATA  bitwise propagate a[i]^b[i]
- cin  input  1  carry-in (1 for subtract)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  LEN_DATA  result
- cout  output  1  carry out of bit LEN_DATA-1
- ovf  output  1  signed overflow
- zero  output  1  sum == 0
- neg  output  1  sum[LEN_DATA-1]

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, skid entry empty, in_ready=1.
  - sum, cout, ovf, zero and neg are all 0.
  - Any bundle in flight is discarded.
- Carry and result arithmetic (combinational, per bundle):
  - c[0] = cin.
  - c[i+1] = g_grp[i] | (p_grp[i] & cin), for i = 0..LEN_DATA-1.
  - sum[i] = p_bit[i] ^ c[i].
  - cout = c[LEN_DATA].
  - ovf = c[LEN_DATA] ^ c[LEN_DATA-1].
  - zero = ~|sum.
  - neg = sum[LEN_DATA-1].
  - The result and all flags are computed before registering and travel together as one bundle.
- Handshake rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - in_ready = ~skid_full, driven from a register only; no combinational path from out_ready to in_ready.
  - Latency is 1 cycle: a bundle accepted at edge N is visible on the outputs after edge N, provided the output register is empty or draining.
- Output register and skid buffer (two storage entries, OUT and SKID):
  - Accept with OUT empty, or OUT draining this cycle and SKID empty: the new bundle loads OUT.
  - Accept with OUT full and not draining: the new bundle loads SKID. in_ready drops on the next cycle.
  - Drain with SKID full: SKID moves to OUT and SKID empties. in_ready rises on the next cycle.
  - Drain with no accept and SKID empty: out_valid=0. Outputs hold their last value and are don't-care for checking.
  - Accept and drain in the same cycle with SKID full cannot occur, because in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, every output stays bit-stable.
- Ordering: bundles leave in acceptance order. None is dropped or duplicated.
- Throughput: 1 bundle/cycle sustained while out_ready=1.
- Boundary cases:
  - All-ones + 1 wraps to 0 with cout=1, zero=1.
  - Maximum positive + 1 gives ovf=1, neg=1.
  - Reset asserted while full empties both entries immediately.
  - in_valid while in_ready=0 is ignored; the source holds its data.

Decomposition:
- main.def.v:
  - LEN_DATA.
  - Flag-bit index constants (FLAG_C=0, FLAG_V=1, FLAG_Z=2, FLAG_N=3) for packing flags on the result bus.
- Sub-module adder_sum_calc (combinational):
  - Inputs: g_grp, p_grp, p_bit, cin.
  - Outputs: sum, cout, ovf, zero, neg.
- adder_sum_pipe holds only the handshake, the OUT/SKID registers and the in_ready register.

Test Plan:
- The bench builds g_grp/p_grp/p_bit from operands a, b with a golden prefix model. All values below assume LEN_DATA=64.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, out_ready=1 -> one cycle later out_valid=1, sum=0, cout=1, zero=1, ovf=0, neg=0.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, ovf=1, neg=1, cout=0, zero=0.
- Subtract 5-7 (a=5, b=~7, cin=1) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, neg=1, ovf=0.
- Backpressure: out_ready=0 while 3 bundles (1+1, 2+2, 3+3) are offered back-to-back.
  - Required: the first two are accepted, then in_ready=0 and the output holds sum=2 stable.
  - Release out_ready -> outputs 2, 4, 6 in order, no loss or duplication.
- Random streams of 10k bundles with random in_valid/out_ready -> scoreboard matches a+b+cin and all flags; out_ready-to-in_ready has no combinational path (checked by formal or lint).
- Assert rst_n low while both entries are full -> out_valid=0 and in_ready=1 asynchronously, all outputs 0. After release, the next bundle 0+0 gives sum=0, zero=1.
